// File: rtl/gate_ctrl.sv
// Measurement sequencer for the equal-precision frequency meter: clear -> arm -> gate -> store.
// Latency: Sig edge reaches the FSM 3 CP cycles later; all outputs are registered (one cycle after each decision).
// Backpressure: none; Start is a level sampled only in IDLE, and waits on Sig are bounded by the preset/wait timers.
module gate_ctrl #(
    parameter int CLR_CYCLES  = 4,
    parameter int GATE_CYCLES = 50000000,
    parameter int TIMEOUT     = 100000000,
    parameter int CONT        = 0,
    parameter int TW          = 27
) (
    input  logic       CP,
    input  logic       RST,
    input  logic       Start,
    input  logic       Sig,
    output logic       Clear,
    output logic       En,
    output logic       Store,
    output logic [1:0] Status_Value,
    output logic       Busy,
    output logic       Done,
    output logic       Timeout
);

    // SETTLE is the one cycle between En falling and Store, so the counters stop before capture.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_GATE,
        S_HOLD,
        S_SETTLE,
        S_STORE,
        S_DONE,
        S_ERR
    } state_t;

    // Timer value seen in the last cycle of each interval (timers start at 0 on entry).
    localparam logic [TW-1:0] CLR_LAST  = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_MAX   = {TW{1'b1}};

    state_t        state_q, state_d;
    logic [TW-1:0] pre_q, pre_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          sig_s1_q, sig_s1_d;
    logic          sig_s2_q, sig_s2_d;
    logic          sig_s3_q, sig_s3_d;
    logic          clear_q, clear_d;
    logic          en_q, en_d;
    logic          store_q, store_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tmo_q, tmo_d;
    logic [1:0]    status_q, status_d;

    logic          sig_rise;
    logic          pre_exp;
    logic          wait_exp;

    assign sig_rise = sig_s2_q & ~sig_s3_q;
    assign pre_exp  = (pre_q >= GATE_LAST);
    assign wait_exp = (wait_q >= WAIT_LAST);

    // Two-flop synchronizer for Sig plus a third flop to find its rising edge.
    always_comb begin
        sig_s1_d = Sig;
        sig_s2_d = sig_s1_q;
        sig_s3_d = sig_s2_q;
    end

    // Sequencer next state; the preset timer runs from ARM entry through GATE without restarting.
    always_comb begin
        state_d = state_q;
        pre_d   = (pre_q == TMR_MAX) ? pre_q : pre_q + TW'(1);
        wait_d  = (wait_q == TMR_MAX) ? wait_q : wait_q + TW'(1);
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_CLEAR;
                    pre_d   = '0;
                end
            end
            S_CLEAR: begin
                if (pre_q >= CLR_LAST) begin
                    state_d = S_ARM;
                    pre_d   = '0;
                    wait_d  = '0;
                end
            end
            S_ARM: begin
                // A Sig edge coinciding with either expiry still opens the gate.
                if (sig_rise) begin
                    state_d = S_GATE;
                end else if (pre_exp || wait_exp) begin
                    state_d = S_ERR;
                end
            end
            S_GATE: begin
                // Sig edges are ignored here, so an edge on the expiry cycle does not close the gate.
                if (pre_exp) begin
                    state_d = S_HOLD;
                    wait_d  = '0;
                end
            end
            S_HOLD: begin
                if (sig_rise) begin
                    state_d = S_SETTLE;
                end else if (wait_exp) begin
                    state_d = S_ERR;
                end
            end
            S_SETTLE: state_d = S_STORE;
            S_STORE:  state_d = S_DONE;
            S_DONE: begin
                if (CONT != 0) begin
                    state_d = S_CLEAR;
                    pre_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (state_d == S_ERR) begin
            tmo_d = 1'b1;
        end else if ((state_d == S_CLEAR) && (state_q != S_CLEAR)) begin
            tmo_d = 1'b0;
        end
    end

    // Output values decoded from the next state so every output comes straight from a flop.
    always_comb begin
        clear_d  = 1'b1;
        en_d     = 1'b0;
        store_d  = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        status_d = 2'b00;
        case (state_d)
            S_CLEAR: begin
                clear_d  = 1'b0;
                status_d = 2'b01;
            end
            S_ARM:    status_d = 2'b11;
            S_GATE, S_HOLD: begin
                en_d     = 1'b1;
                status_d = 2'b11;
            end
            S_SETTLE: status_d = 2'b11;
            S_STORE: begin
                store_d  = 1'b1;
                status_d = 2'b10;
            end
            S_DONE:   done_d = 1'b1;
            S_ERR:    done_d = 1'b1;
            default:  status_d = 2'b00;
        endcase
    end

    // State, timers, synchronizer and output registers; reset drops En and all pulses at once.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            wait_q   <= '0;
            sig_s1_q <= 1'b0;
            sig_s2_q <= 1'b0;
            sig_s3_q <= 1'b0;
            clear_q  <= 1'b1;
            en_q     <= 1'b0;
            store_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            wait_q   <= wait_d;
            sig_s1_q <= sig_s1_d;
            sig_s2_q <= sig_s2_d;
            sig_s3_q <= sig_s3_d;
            clear_q  <= clear_d;
            en_q     <= en_d;
            store_q  <= store_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            status_q <= status_d;
        end
    end

    assign Clear        = clear_q;
    assign En           = en_q;
    assign Store        = store_q;
    assign Status_Value = status_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Timeout      = tmo_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Bench for gate_ctrl: one single-shot instance and one continuous-mode instance share CP and Sig.
// Expected outcomes are queued when Start is issued; a negedge monitor checks each Done against the queue.
// Sig is a programmed square wave so the reference can predict every edge the FSM will see.
`timescale 1ns/1ps
module tb_gate_ctrl;

    localparam int CLR = 4;
    localparam int G0  = 100;
    localparam int T0  = 500;
    localparam int G1  = 100;
    localparam int T1  = 60;
    localparam int TW  = 12;

    typedef struct {
        int done_cyc;
        int en_len;
        bit store;
        bit tmo;
    } exp_t;

    logic       CP = 1'b0;
    logic       sig = 1'b0;
    logic [1:0] start_v = 2'b00;
    logic [1:0] rst_v = 2'b11;
    logic [1:0] clr_v, en_v, store_v, busy_v, done_v, tmo_v;
    logic [1:0] stat_v [2];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    int sig_per  = 10;
    int sig_ph   = 1 << 30;
    int sig_stop = 1 << 30;

    gate_ctrl #(.CLR_CYCLES(CLR), .GATE_CYCLES(G0), .TIMEOUT(T0), .CONT(0), .TW(TW)) u_single (
        .CP(CP), .RST(rst_v[0]), .Start(start_v[0]), .Sig(sig),
        .Clear(clr_v[0]), .En(en_v[0]), .Store(store_v[0]), .Status_Value(stat_v[0]),
        .Busy(busy_v[0]), .Done(done_v[0]), .Timeout(tmo_v[0])
    );

    gate_ctrl #(.CLR_CYCLES(CLR), .GATE_CYCLES(G1), .TIMEOUT(T1), .CONT(1), .TW(TW)) u_cont (
        .CP(CP), .RST(rst_v[1]), .Start(start_v[1]), .Sig(sig),
        .Clear(clr_v[1]), .En(en_v[1]), .Store(store_v[1]), .Status_Value(stat_v[1]),
        .Busy(busy_v[1]), .Done(done_v[1]), .Timeout(tmo_v[1])
    );

    always #5 CP = ~CP;

    initial forever begin
        @(posedge CP);
        cyc = cyc + 1;
    end

    // Sig level driven just after edge k; it is high for the first half of each period.
    function automatic bit sigf(int k);
        if (k < sig_ph || k >= sig_stop) return 1'b0;
        return ((k - sig_ph) % sig_per) < (sig_per / 2);
    endfunction

    // A level driven after edge k passes two sync flops and the edge flop: the FSM acts on it at edge k+3.
    function automatic bit rise_at(int e);
        return sigf(e - 3) && !sigf(e - 4);
    endfunction

    initial forever begin
        @(posedge CP);
        #1;
        sig = sigf(cyc);
    end

    // Reference: measurement started at edge s. ARM begins CLR edges later; gate opens on the first
    // Sig edge within min(gate,timeout) cycles, hold begins when the gate preset (counted from ARM)
    // has run out, and the gate closes on the next Sig edge within the timeout.
    function automatic exp_t model(int s, int g, int t);
        exp_t r;
        int a, lim, r0, r1, hold;
        a   = s + CLR;
        lim = a + ((g < t) ? g : t);
        r0  = -1;
        r1  = -1;
        for (int e = a + 1; e <= lim && r0 < 0; e++) if (rise_at(e)) r0 = e;
        if (r0 < 0) begin
            r.done_cyc = lim; r.en_len = 0; r.store = 1'b0; r.tmo = 1'b1;
            return r;
        end
        hold = (a + g > r0 + 1) ? a + g : r0 + 1;
        for (int e = hold + 1; e <= hold + t && r1 < 0; e++) if (rise_at(e)) r1 = e;
        if (r1 < 0) begin
            r.done_cyc = hold + t; r.en_len = hold + t - r0; r.store = 1'b0; r.tmo = 1'b1;
        end else begin
            r.done_cyc = r1 + 2; r.en_len = r1 - r0; r.store = 1'b1; r.tmo = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t pop_exp(int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Monitor: accumulate what each instance does during a measurement and judge it at Done.
    int   m_clr [2];
    int   m_en [2];
    int   m_store [2];
    int   m_store_cyc [2];
    int   m_stat_bad [2];
    int   m_tmo_clr [2];
    bit   m_en_prev [2];
    bit   m_done_prev [2];
    bit   m_last_tmo [2];
    exp_t m_r;

    initial forever begin
        @(negedge CP);
        for (int i = 0; i < 2; i++) begin
            if (rst_v[i]) begin
                m_clr[i] = 0; m_en[i] = 0; m_store[i] = 0; m_store_cyc[i] = 0;
                m_stat_bad[i] = 0; m_tmo_clr[i] = 0; m_en_prev[i] = 1'b0; m_done_prev[i] = 1'b0;
            end else begin
                if (m_done_prev[i])
                    chk($sformatf("busy_after_done[%0d]", i), busy_v[i], (i == 1 && !m_last_tmo[i]) ? 1 : 0);
                if (!clr_v[i]) begin
                    m_clr[i] = m_clr[i] + 1;
                    if (stat_v[i] != 2'b01 || !busy_v[i]) m_stat_bad[i] = m_stat_bad[i] + 1;
                    if (tmo_v[i]) m_tmo_clr[i] = m_tmo_clr[i] + 1;
                end
                if (en_v[i] && !m_en_prev[i]) chk($sformatf("en_rise_status[%0d]", i), stat_v[i], 3);
                if (en_v[i]) m_en[i] = m_en[i] + 1;
                if (store_v[i]) begin
                    m_store[i] = m_store[i] + 1;
                    m_store_cyc[i] = cyc;
                    chk($sformatf("store_status[%0d]", i), stat_v[i], 2);
                end
                if (done_v[i]) begin
                    chk($sformatf("done_expected[%0d]", i), (qsize(i) > 0) ? 1 : 0, 1);
                    chk($sformatf("done_status[%0d]", i), stat_v[i], 0);
                    if (qsize(i) > 0) begin
                        m_r = pop_exp(i);
                        chk($sformatf("done_cycle[%0d]", i), cyc, m_r.done_cyc);
                        chk($sformatf("en_length[%0d]", i), m_en[i], m_r.en_len);
                        chk($sformatf("store_count[%0d]", i), m_store[i], m_r.store ? 1 : 0);
                        if (m_r.store) chk($sformatf("store_cycle[%0d]", i), m_store_cyc[i], cyc - 1);
                        chk($sformatf("timeout_flag[%0d]", i), tmo_v[i], m_r.tmo ? 1 : 0);
                        chk($sformatf("clear_length[%0d]", i), m_clr[i], CLR);
                        chk($sformatf("clear_phase_status[%0d]", i), m_stat_bad[i], 0);
                        chk($sformatf("timeout_cleared[%0d]", i), m_tmo_clr[i], 0);
                        m_last_tmo[i] = m_r.tmo;
                    end
                    m_clr[i] = 0; m_en[i] = 0; m_store[i] = 0; m_stat_bad[i] = 0; m_tmo_clr[i] = 0;
                end
                m_en_prev[i] = en_v[i];
                m_done_prev[i] = done_v[i];
            end
        end
    end

    // Program Sig relative to the start edge s, pulse Start, and queue the predicted outcome(s).
    task automatic launch(input int inst, input int per, input int ph_off, input int stop_off, input bit push);
        int   s;
        exp_t r;
        bit   go;
        @(posedge CP); #2;
        s = cyc + 1;
        sig_per = per; sig_ph = s + ph_off; sig_stop = s + stop_off;
        start_v[inst] = 1'b1;
        @(posedge CP); #2;
        start_v[inst] = 1'b0;
        if (push) begin
            if (inst == 0) begin
                q0.push_back(model(s, G0, T0));
            end else begin
                go = 1'b1;
                for (int n = 0; n < 20 && go; n++) begin
                    r = model(s, G1, T1);
                    q1.push_back(r);
                    if (r.tmo) go = 1'b0;
                    s = r.done_cyc + 1;
                end
            end
        end
    endtask

    task automatic poke(input int inst, input int dly);
        repeat (dly) @(posedge CP);
        #2; start_v[inst] = 1'b1;
        @(posedge CP); #2; start_v[inst] = 1'b0;
    endtask

    task automatic drain(input int inst, input int budget);
        int n;
        n = 0;
        while (qsize(inst) != 0 && n < budget) begin
            @(posedge CP);
            n = n + 1;
        end
        chk($sformatf("drain[%0d]", inst), qsize(inst), 0);
        repeat (3) @(posedge CP);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge CP);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_clear[%0d]", i), clr_v[i], 1);
            chk($sformatf("rst_en[%0d]", i), en_v[i], 0);
            chk($sformatf("rst_store[%0d]", i), store_v[i], 0);
            chk($sformatf("rst_status[%0d]", i), stat_v[i], 0);
            chk($sformatf("rst_busy[%0d]", i), busy_v[i], 0);
            chk($sformatf("rst_done[%0d]", i), done_v[i], 0);
            chk($sformatf("rst_timeout[%0d]", i), tmo_v[i], 0);
        end
        #1; rst_v = 2'b00;
        repeat (3) @(posedge CP);

        // Period 30, first edge 5 cycles into ARM: four whole periods of gate.
        launch(0, 30, 6, 1 << 20, 1'b1); drain(0, 2000);
        // Sig held low: preset expires in ARM.
        launch(0, 30, 1 << 20, 1 << 20, 1'b1); drain(0, 2000);
        // Sig stops before HOLD: wait timer closes the gate.
        launch(0, 30, 6, 110, 1'b1); drain(0, 2000);
        // A clean run right after an error clears the sticky flag.
        launch(0, 30, 6, 1 << 20, 1'b1); drain(0, 2000);
        // Sig edge on the preset-expiry cycle while still in ARM.
        launch(0, 20, 101, 1 << 20, 1'b1); drain(0, 2000);
        // Sig edge on the preset-expiry cycle while in GATE.
        launch(0, 20, 81, 1 << 20, 1'b1); drain(0, 2000);

        for (int k = 0; k < 10; k++) begin
            launch(0, $urandom_range(4, 60), $urandom_range(2, 140),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(20, 250) : (1 << 20), 1'b1);
            poke(0, $urandom_range(5, 50));
            drain(0, 2000);
        end

        // Continuous mode: back-to-back runs until Sig stops and one aborts.
        launch(1, 37, 6, 700, 1'b1);
        poke(1, 30);
        drain(1, 5000);
        launch(1, $urandom_range(20, 55), $urandom_range(2, 40), $urandom_range(300, 900), 1'b1);
        poke(1, $urandom_range(5, 50));
        drain(1, 5000);

        // Reset in the middle of a gate; nothing is queued, so any later Done is flagged.
        launch(0, 30, 6, 1 << 20, 1'b0);
        n = 0;
        while (!en_v[0] && n < 300) begin
            @(posedge CP);
            n = n + 1;
        end
        chk("gate_reached_before_reset", en_v[0], 1);
        repeat (10) @(posedge CP);
        #3; rst_v[0] = 1'b1;
        #1;
        chk("midrst_en", en_v[0], 0);
        chk("midrst_clear", clr_v[0], 1);
        chk("midrst_store", store_v[0], 0);
        chk("midrst_done", done_v[0], 0);
        chk("midrst_busy", busy_v[0], 0);
        chk("midrst_timeout", tmo_v[0], 0);
        chk("midrst_status", stat_v[0], 0);
        @(posedge CP); #2; rst_v[0] = 1'b0;
        repeat (700) @(posedge CP);
        #1;
        chk("after_rst_idle", busy_v[0], 0);

        chk("final_queue0", q0.size(), 0);
        chk("final_queue1", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
